// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar-graph segment sequencer.
// Level fields are 0..MAX_LEVEL; anything larger is clamped when a segment loads.
package led_bar_pkg;
   localparam int LEVEL_W = 5;
   localparam int HOLD_W  = 4;
   localparam int NUM_SEG = 4;
   localparam int IDX_W   = 2;
   localparam logic [LEVEL_W-1:0] MAX_LEVEL = 5'd16;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   typedef struct packed {
      logic [LEVEL_W-1:0] start_lvl;
      logic [LEVEL_W-1:0] end_lvl;
      logic [HOLD_W-1:0]  hold;
   } seg_t;

   function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] v);
      return (v > MAX_LEVEL) ? MAX_LEVEL : v;
   endfunction

   // 0 behaves as one segment, anything past the table depth as the full table
   function automatic logic [2:0] eff_num_seg(input logic [2:0] n);
      if (n == 3'd0) return 3'd1;
      if (n > 3'd4)  return 3'd4;
      return n;
   endfunction
endpackage

// File: rtl/led_seg_table.sv
// Four-entry segment table: synchronous write, combinational read.
// Reset clears every entry and takes priority over a simultaneous write.
module led_seg_table
   import led_bar_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  seg_t             wdata,
   input  logic [IDX_W-1:0] raddr,
   output seg_t             rdata
);
   seg_t entries [NUM_SEG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SEG; i++) entries[i] <= '0;
      end else if (we) begin
         entries[waddr] <= wdata;
      end
   end

   assign rdata = entries[raddr];
endmodule

// File: rtl/led_bar_sequencer.sv
// Plays up to four start/end/dwell segments on the bar level, once or looping.
// state | meaning
// IDLE  | level parked at last value, waiting for go
// LOAD  | one cycle: copy active entry into working regs, level <= start
// RUN   | step level toward end by one per tick
// HOLD  | dwell at end for hold ticks, then advance to next segment or finish
module led_bar_sequencer
   import led_bar_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [LEVEL_W-1:0] cfg_start,
   input  logic [LEVEL_W-1:0] cfg_end,
   input  logic [HOLD_W-1:0]  cfg_hold,
   input  logic [2:0]         num_seg,
   input  logic               loop_en,
   input  logic               go,
   input  logic               stop,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         seg_idx,
   output logic               busy,
   output logic               seg_done,
   output logic               all_done
);
   state_t             state, state_nxt;
   seg_t               wr_seg, rd_seg;
   logic [LEVEL_W-1:0] ld_start, ld_end, w_end, step_lvl;
   logic [HOLD_W-1:0]  w_hold, dwell;
   logic               dir_up, seg_last, hold_met;
   logic               start_en, load_en, step_en, dwell_en, adv_en;

   assign wr_seg = '{start_lvl: cfg_start, end_lvl: cfg_end, hold: cfg_hold};

   led_seg_table u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdata (wr_seg),
      .raddr (seg_idx),
      .rdata (rd_seg)
   );

   assign ld_start = clamp_level(rd_seg.start_lvl);
   assign ld_end   = clamp_level(rd_seg.end_lvl);
   assign step_lvl = dir_up ? level + LEVEL_W'(1) : level - LEVEL_W'(1);
   assign seg_last = ({1'b0, seg_idx} + 3'd1) >= eff_num_seg(num_seg);
   assign hold_met = (dwell == w_hold);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (go) state_nxt = LOAD;
         LOAD: state_nxt = (ld_start == ld_end) ? HOLD : RUN;
         RUN:  if (tick && step_lvl == w_end) state_nxt = HOLD;
         HOLD: if (hold_met) state_nxt = (seg_last && !loop_en) ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
      if (stop) state_nxt = IDLE;
   end

   // stop freezes the datapath: no step, no load, no advance, no pulses
   always_comb begin
      start_en = 1'b0;
      load_en  = 1'b0;
      step_en  = 1'b0;
      dwell_en = 1'b0;
      adv_en   = 1'b0;
      if (!stop) begin
         case (state)
            IDLE: start_en = go;
            LOAD: load_en  = 1'b1;
            RUN:  step_en  = tick;
            HOLD: begin
               if (hold_met) adv_en   = 1'b1;
               else          dwell_en = tick;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level    <= '0;
         seg_idx  <= '0;
         w_end    <= '0;
         w_hold   <= '0;
         dir_up   <= 1'b1;
         dwell    <= '0;
         seg_done <= 1'b0;
         all_done <= 1'b0;
      end else begin
         seg_done <= adv_en;
         all_done <= adv_en && seg_last && !loop_en;
         if (start_en) seg_idx <= '0;
         if (load_en) begin
            level  <= ld_start;
            w_end  <= ld_end;
            w_hold <= rd_seg.hold;
            dir_up <= (ld_end >= ld_start);
            dwell  <= '0;
         end
         if (step_en) begin
            level <= step_lvl;
            if (step_lvl == w_end) dwell <= '0;
         end
         if (dwell_en) dwell <= dwell + HOLD_W'(1);
         if (adv_en && !seg_last)    seg_idx <= seg_idx + 2'd1;
         else if (adv_en && loop_en) seg_idx <= '0;
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_led_bar_sequencer.sv
// Bench for led_bar_sequencer: vector table, directed corner sequences, and
// random tables/tick patterns checked against a tick-counting timeline model.
module tb_led_bar_sequencer;
   localparam int N = 400;

   logic       clk = 1'b0;
   logic       rst, tick, cfg_we, loop_en, go, stop;
   logic [1:0] cfg_addr;
   logic [4:0] cfg_start, cfg_end;
   logic [3:0] cfg_hold;
   logic [2:0] num_seg;
   logic [4:0] level;
   logic [1:0] seg_idx;
   logic       busy, seg_done, all_done;

   int total = 0;
   int bad   = 0;

   led_bar_sequencer dut (
      .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_hold(cfg_hold),
      .num_seg(num_seg), .loop_en(loop_en), .go(go), .stop(stop),
      .level(level), .seg_idx(seg_idx), .busy(busy),
      .seg_done(seg_done), .all_done(all_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s; int e; int h;
      int exp_lvl; int exp_done;
   } vec_t;
   vec_t vecs[8];

   logic [9:0] exp_tr [N];
   bit         tick_pat [N];
   int         m_end;
   int         tab_s[4], tab_e[4], tab_h[4];
   int         lv_q[$], exp_q[$];
   int         n_sd, n_ad, n_co;

   int loop_lv[12] = '{0, 0, 1, 2, 2, 2, 1, 0, 0, 0, 1, 2};
   int loop_ix[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
   int loop_sd[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; go = 1'b0; stop = 1'b0; cfg_we = 1'b0; loop_en = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic wr(input int a, input int s, input int e, input int h);
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_start = 5'(s); cfg_end = 5'(e); cfg_hold = 4'(h);
      step();
      cfg_we = 1'b0;
   endtask

   function automatic int clampv(input int v);
      return (v > 16) ? 16 : v;
   endfunction

   task automatic put(input int c, input int lv, input int ix, input int b, input int sd, input int ad);
      if (c < N) exp_tr[c] = {5'(lv), 2'(ix), 1'(b), 1'(sd), 1'(ad)};
   endtask

   // Timeline from the segment rules: LOAD cycle, |d| counted ticks, hold counted
   // ticks, one decision cycle; pulses show up in the following cycle.
   task automatic build_model(input int ns);
      int lvl = 0, s = 0, c = 0, ld = 1, sd = 0, st, en, d, cnt, steps;
      bit up;
      put(0, 0, 0, 0, 0, 0);
      forever begin
         st = clampv(tab_s[s]); en = clampv(tab_e[s]);
         up = (en >= st);
         d  = up ? en - st : st - en;
         put(ld, lvl, s, 1, sd, 0);
         lvl = st; c = ld + 1; steps = 0;
         while (steps < d && c < N) begin
            put(c, lvl, s, 1, 0, 0);
            if (tick_pat[c]) begin steps++; lvl += up ? 1 : -1; end
            c++;
         end
         cnt = 0;
         while (cnt < tab_h[s] && c < N) begin
            put(c, lvl, s, 1, 0, 0);
            if (tick_pat[c]) cnt++;
            c++;
         end
         put(c, lvl, s, 1, 0, 0);
         if (c + 3 >= N) begin
            m_end = (c < N) ? c : N - 1;
            return;
         end
         if (s < ns - 1) begin
            s++; ld = c + 1; sd = 1;
         end else begin
            for (int k = c + 1; k < N; k++) put(k, lvl, s, 0, int'(k == c + 1), int'(k == c + 1));
            m_end = c + 3;
            return;
         end
      end
   endtask

   task automatic run_until_idle(input int period, input int max_cyc, output bit ok);
      int prev;
      prev = level; lv_q.delete(); n_sd = 0; n_ad = 0; n_co = 0; ok = 0;
      go = 1'b1; tick = 1'b0;
      step();
      go = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         if (int'(level) != prev) begin lv_q.push_back(int'(level)); prev = level; end
         if (seg_done) n_sd++;
         if (all_done) n_ad++;
         if (seg_done && all_done) n_co++;
         if (!busy) begin ok = 1; break; end
         tick = ((c % period) == period - 1);
         step();
      end
      tick = 1'b0;
   endtask

   task automatic check_seq(input string nm);
      check({nm, "_len"}, lv_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < lv_q.size(); i++) check({nm, "_lvl"}, lv_q[i], exp_q[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cyc, ns_in, ns_eff;
      vecs[0] = '{2, 6, 0, 6, 7};
      vecs[1] = '{10, 7, 3, 7, 9};
      vecs[2] = '{20, 16, 0, 16, 3};
      vecs[3] = '{0, 0, 0, 0, 3};
      vecs[4] = '{31, 0, 2, 0, 21};
      vecs[5] = '{5, 30, 1, 16, 15};
      vecs[6] = '{9, 9, 5, 9, 8};
      vecs[7] = '{17, 3, 0, 3, 16};
      cfg_addr = '0; cfg_start = '0; cfg_end = '0; cfg_hold = '0; num_seg = 3'd1;

      do_reset();
      check("reset_outputs", {level, seg_idx, busy, seg_done, all_done}, 0);

      // single segments, tick every cycle: done at cycle |d| + hold + 3 after go
      foreach (vecs[i]) begin
         do_reset();
         wr(0, vecs[i].s, vecs[i].e, vecs[i].h);
         num_seg = 3'd1;
         go = 1'b1; tick = 1'b1;
         step();
         go = 1'b0; cyc = 1;
         while (!all_done && cyc < 60) begin step(); cyc++; end
         check("vec_done_cycle", cyc, vecs[i].exp_done);
         check("vec_level", level, vecs[i].exp_lvl);
         check("vec_busy", busy, 0);
      end

      // up segment, tick every 4 cycles
      do_reset(); wr(0, 2, 6, 0); num_seg = 3'd1;
      run_until_idle(4, 100, ok);
      check("up_finished", ok, 1);
      exp_q.delete(); for (int v = 2; v <= 6; v++) exp_q.push_back(v);
      check_seq("up");
      check("up_seg_done", n_sd, 1); check("up_all_done", n_ad, 1); check("up_coincide", n_co, 1);
      check("up_final", level, 6);

      // down with dwell
      do_reset(); wr(0, 10, 7, 3);
      run_until_idle(4, 100, ok);
      check("down_finished", ok, 1);
      exp_q.delete(); for (int v = 10; v >= 7; v--) exp_q.push_back(v);
      check_seq("down");
      check("down_all_done", n_ad, 1); check("down_final", level, 7);

      // clamp + equal: done two cycles after LOAD without any tick
      do_reset(); wr(0, 20, 16, 0);
      go = 1'b1; step(); go = 1'b0;
      check("eq_load_busy", busy, 1);
      step(); check("eq_hold_level", level, 16);
      step(); check("eq_done", {seg_done, all_done, busy}, 3'b110);

      // two-segment loop, tick every cycle, then drop loop_en
      do_reset(); wr(0, 0, 2, 0); wr(1, 2, 0, 0);
      num_seg = 3'd2; loop_en = 1'b1;
      go = 1'b1; tick = 1'b1; step(); go = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("loop_level", level, loop_lv[i]);
         check("loop_idx", seg_idx, loop_ix[i]);
         check("loop_seg_done", seg_done, loop_sd[i]);
         step();
      end
      loop_en = 1'b0; cyc = 0;
      while (!all_done && cyc < 40) begin step(); cyc++; end
      check("loop_end_all_done", all_done, 1);
      check("loop_end_idx", seg_idx, 1);
      check("loop_end_level", level, 0);
      tick = 1'b0; num_seg = 3'd1;

      // stop and go together in RUN at level 5
      do_reset(); wr(0, 2, 9, 0);
      go = 1'b1; tick = 1'b1; step(); go = 1'b0; cyc = 0;
      while (level != 5'd5 && cyc < 20) begin step(); cyc++; end
      check("stop_reached5", level, 5);
      stop = 1'b1; go = 1'b1;
      step();
      stop = 1'b0; go = 1'b0; tick = 1'b0;
      check("stop_state", {level, busy, seg_done, all_done}, {5'd5, 3'b000});
      tick = 1'b1; step(); step(); tick = 1'b0;
      check("stop_hold", {level, busy}, {5'd5, 1'b0});
      go = 1'b1; step(); go = 1'b0;
      check("restart_busy_idx", {busy, seg_idx}, 3'b100);
      step(); check("restart_level", level, 2);

      // reset in RUN with a simultaneous table write
      do_reset(); wr(0, 3, 12, 2);
      go = 1'b1; tick = 1'b1; step(); go = 1'b0; cyc = 0;
      while (level != 5'd6 && cyc < 20) begin step(); cyc++; end
      rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_start = 5'd7; cfg_end = 5'd9; cfg_hold = 4'd0;
      step();
      rst = 1'b0; cfg_we = 1'b0; tick = 1'b0;
      check("rst_run_outputs", {level, seg_idx, busy, seg_done, all_done}, 0);
      go = 1'b1; step(); go = 1'b0; step(); step();
      check("rst_cleared_done", {level, busy, seg_done, all_done}, {5'd0, 3'b011});

      // random tables, segment counts and tick patterns
      for (int it = 0; it < 30; it++) begin
         do_reset();
         for (int a = 0; a < 4; a++) begin
            tab_s[a] = $urandom_range(0, 31);
            tab_e[a] = $urandom_range(0, 31);
            tab_h[a] = $urandom_range(0, 4);
            wr(a, tab_s[a], tab_e[a], tab_h[a]);
         end
         ns_in  = $urandom_range(0, 7);
         ns_eff = (ns_in == 0) ? 1 : (ns_in > 4) ? 4 : ns_in;
         num_seg = 3'(ns_in);
         for (int c = 0; c < N; c++) tick_pat[c] = ($urandom_range(0, 2) != 0);
         build_model(ns_eff);
         go = 1'b1; tick = tick_pat[0];
         step();
         go = 1'b0;
         for (int c = 1; c <= m_end; c++) begin
            check("rand_trace", {level, seg_idx, busy, seg_done, all_done}, exp_tr[c]);
            tick = tick_pat[c];
            step();
         end
         tick = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
